// File: rtl/reg_univ.sv
// Universal N-bit register: hold, load, shift left/right, modulo-M count up/down, clear.
// Define REG_UNIV_SAT_EN to make the count modes saturate instead of wrapping.
module reg_univ #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [2:0]   mode,
  input  logic [N-1:0] x,
  input  logic         sin,
  output logic [N-1:0] z,
  output logic         tc_up,
  output logic         tc_dn,
  output logic         ovf
);

  typedef enum logic [2:0] {
    ModeHold  = 3'b000,
    ModeLoad  = 3'b001,
    ModeShl   = 3'b010,
    ModeShr   = 3'b011,
    ModeUp    = 3'b100,
    ModeDown  = 3'b101,
    ModeClear = 3'b110,
    ModeRsvd  = 3'b111
  } mode_e;

  localparam logic [N-1:0] MaxVal = N'(M - 1);

`ifdef REG_UNIV_SAT_EN
  localparam logic [N-1:0] UpWrap = MaxVal;
  localparam logic [N-1:0] DnWrap = '0;
`else
  localparam logic [N-1:0] UpWrap = '0;
  localparam logic [N-1:0] DnWrap = MaxVal;
`endif

  logic [N-1:0] z_q, z_d;
  logic         ovf_q, ovf_d;

  always_comb begin
    z_d   = z_q;
    ovf_d = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        ModeLoad:  z_d = x;
        ModeShl:   z_d = {z_q[N-2:0], sin};
        ModeShr:   z_d = {sin, z_q[N-1:1]};
        ModeUp: begin
          // Values at or above the terminal count all take the boundary path.
          if (z_q >= MaxVal) begin
            z_d   = UpWrap;
            ovf_d = 1'b1;
          end else begin
            z_d = z_q + N'(1);
          end
        end
        ModeDown: begin
          if (z_q == '0) begin
            z_d   = DnWrap;
            ovf_d = 1'b1;
          end else if (z_q > MaxVal) begin
            z_d   = MaxVal;
            ovf_d = 1'b1;
          end else begin
            z_d = z_q - N'(1);
          end
        end
        ModeClear: z_d = '0;
        default:   z_d = z_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      ovf_q <= ovf_d;
    end
  end

  assign z     = z_q;
  assign ovf   = ovf_q;
  assign tc_up = (z_q == MaxVal);
  assign tc_dn = (z_q == '0);

endmodule

// File: tb/tb_reg_univ.sv
// Self-checking bench for reg_univ: M=4 and M=256 instances share stimulus, each tracked
// by an arithmetic reference model, plus directed literal checks.
module tb_reg_univ;

  localparam int N    = 8;
  localparam int Mask = (1 << N) - 1;
`ifdef REG_UNIV_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic [N-1:0] x = '0;
  logic         sin = 1'b0;

  logic [N-1:0] z4, z256;
  logic         tcu4, tcd4, ovf4, tcu256, tcd256, ovf256;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_univ #(.N(8), .M(4)) u_m4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .x(x), .sin(sin),
    .z(z4), .tc_up(tcu4), .tc_dn(tcd4), .ovf(ovf4)
  );

  reg_univ #(.N(8), .M(256)) u_m256 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .x(x), .sin(sin),
    .z(z256), .tc_up(tcu256), .tc_dn(tcd256), .ovf(ovf256)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference behaviour written directly from the operation table.
  function automatic void model_next(input int zc, input int m, input bit e,
                                     input int md, input int xv, input bit s,
                                     output int nz, output bit no);
    nz = zc;
    no = 1'b0;
    if (e) begin
      case (md)
        1: nz = xv;
        2: nz = ((zc << 1) | int'(s)) & Mask;
        3: nz = (s ? (1 << (N - 1)) : 0) | (zc >> 1);
        4: begin
          if (zc >= m - 1) begin
            no = 1'b1;
            nz = Sat ? m - 1 : 0;
          end else nz = zc + 1;
        end
        5: begin
          if (zc == 0) begin
            no = 1'b1;
            nz = Sat ? 0 : m - 1;
          end else if (zc > m - 1) begin
            no = 1'b1;
            nz = m - 1;
          end else nz = zc - 1;
        end
        6: nz = 0;
        default: nz = zc;
      endcase
    end
  endfunction

  int m4_z = 0, m256_z = 0;
  bit m4_o = 0, m256_o = 0;

  always @(posedge clk or negedge rst_n) begin
    int nz4, nz256;
    bit no4, no256;
    if (!rst_n) begin
      m4_z   <= 0;
      m4_o   <= 1'b0;
      m256_z <= 0;
      m256_o <= 1'b0;
    end else begin
      model_next(m4_z, 4, en, int'(mode), int'(x), sin, nz4, no4);
      model_next(m256_z, 256, en, int'(mode), int'(x), sin, nz256, no256);
      m4_z   <= nz4;
      m4_o   <= no4;
      m256_z <= nz256;
      m256_o <= no256;
    end
  end

  always @(negedge clk) begin
    chk("m4_z", int'(z4), m4_z);
    chk("m4_ovf", int'(ovf4), int'(m4_o));
    chk("m4_tc_up", int'(tcu4), int'(m4_z == 3));
    chk("m4_tc_dn", int'(tcd4), int'(m4_z == 0));
    chk("m256_z", int'(z256), m256_z);
    chk("m256_ovf", int'(ovf256), int'(m256_o));
    chk("m256_tc_up", int'(tcu256), int'(m256_z == 255));
    chk("m256_tc_dn", int'(tcd256), int'(m256_z == 0));
  end

  task automatic step(input bit e, input logic [2:0] md, input logic [N-1:0] xv, input bit s);
    en   = e;
    mode = md;
    x    = xv;
    sin  = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_z", int'(z4), 0);
    chk("rst_tc_dn", int'(tcd4), 1);
    chk("rst_tc_up", int'(tcu4), 0);
    chk("rst_ovf", int'(ovf4), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Count up modulo 4
    step(1, 3'b100, 8'h00, 0); chk("up1", int'(z4), 1); chk("up1_ovf", int'(ovf4), 0);
    step(1, 3'b100, 8'h00, 0); chk("up2", int'(z4), 2);
    step(1, 3'b100, 8'h00, 0); chk("up3", int'(z4), 3); chk("up3_tc_up", int'(tcu4), 1);
    step(1, 3'b100, 8'h00, 0); chk("up4", int'(z4), Sat ? 3 : 0); chk("up4_ovf", int'(ovf4), 1);
    step(1, 3'b100, 8'h00, 0); chk("up5", int'(z4), Sat ? 3 : 1); chk("up5_ovf", int'(ovf4), 1 - 1 + int'(Sat));
    chk("up5_m256", int'(z256), 5);

    // Down from zero
    step(1, 3'b110, 8'h00, 0); chk("clr", int'(z4), 0); chk("clr_ovf", int'(ovf4), 0);
    step(1, 3'b101, 8'h00, 0); chk("dn0", int'(z4), Sat ? 0 : 3); chk("dn0_ovf", int'(ovf4), 1);

    // Load and shifts
    step(1, 3'b001, 8'hA5, 0); chk("ld_a5", int'(z4), 'hA5);
    step(1, 3'b010, 8'h00, 1); chk("shl", int'(z4), 'h4B); chk("shl_ovf", int'(ovf4), 0);
    step(1, 3'b011, 8'h00, 0); chk("shr", int'(z4), 'h25);

    // Out-of-range counts
    step(1, 3'b001, 8'hF0, 0);
    step(1, 3'b100, 8'h00, 0); chk("up_big", int'(z4), Sat ? 3 : 0); chk("up_big_ovf", int'(ovf4), 1);
    step(1, 3'b001, 8'hF0, 0);
    step(1, 3'b101, 8'h00, 0); chk("dn_big", int'(z4), 3); chk("dn_big_ovf", int'(ovf4), 1);

    // Mid-cycle reset while counting
    step(1, 3'b110, 8'h00, 0);
    step(1, 3'b100, 8'h00, 0);
    step(1, 3'b100, 8'h00, 0); chk("pre_rst", int'(z4), 2);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_z", int'(z4), 0); chk("mid_rst_ovf", int'(ovf4), 0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Reset discards a pending ovf
    step(1, 3'b001, 8'h03, 0);
    step(1, 3'b100, 8'h00, 0); chk("pend_ovf", int'(ovf4), 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_ovf_clr", int'(ovf4), 0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Enable low holds and clears ovf
    step(1, 3'b001, 8'h03, 0);
    step(1, 3'b100, 8'h00, 0);
    step(0, 3'b100, 8'h00, 0); chk("en0_z", int'(z4), Sat ? 3 : 0); chk("en0_ovf", int'(ovf4), 0);
    step(1, 3'b001, 8'h02, 0);
    step(0, 3'b100, 8'h00, 0);
    step(0, 3'b100, 8'h00, 0); chk("en0_hold", int'(z4), 2);
    step(1, 3'b000, 8'hFF, 1); chk("hold", int'(z4), 2);
    step(1, 3'b111, 8'hFF, 1); chk("rsvd", int'(z4), 2); chk("rsvd_ovf", int'(ovf4), 0);

    // Full-range binary wrap and clear
    step(1, 3'b001, 8'hFF, 0);
    step(1, 3'b100, 8'h00, 0); chk("m256_wrap", int'(z256), Sat ? 'hFF : 0);
    chk("m256_wrap_ovf", int'(ovf256), 1);
    step(1, 3'b001, 8'h37, 0);
    step(1, 3'b110, 8'h00, 0); chk("m256_clr", int'(z256), 0); chk("m256_clr_ovf", int'(ovf256), 0);

    // Pseudo-random traffic checked by the model on every cycle
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
